pipelined_approx_adder: RTL and testbench
=========================================

// Module: pipelined_approx_adder
// PURPOSE
//   Parametrised, pipelined successor to the 16-bit ripple-carry adder.
//   - Carry chain cut into SEG_W-bit segments, one register stage per segment.
//   - Per-transaction mode: exact, or lower-part-OR approximate (LOA).
//   - valid/ready handshake on input and output.
//   - Serves as the throughput-oriented adder for datapaths and error-characterisation benches.
// PARAMETERS
//   WIDTH        16  operand width; must be a multiple of SEG_W
//   SEG_W        4   bits per pipeline segment; STAGES = WIDTH/SEG_W (localparam)
//   APPROX_BITS  4   LSBs computed approximately in LOA mode; 0..WIDTH
// PORTS
//   clk_i     in   1        clock; one clock, all logic on rising edge
//   rst_ni    in   1        reset; synchronous, active-low
//   valid_i   in   1        input transaction valid
//   ready_o   out  1        block accepts input this cycle
//   add1_i    in   WIDTH    operand A
//   add2_i    in   WIDTH    operand B
//   mode_i    in   1        0 = exact, 1 = LOA approximate
//   valid_o   out  1        result_o/mode_o valid
//   ready_i   in   1        downstream accepts result
//   result_o  out  WIDTH+1  sum; MSB = carry out
//   mode_o    out  1        mode the result was computed with
// BEHAVIOUR
//   Reset
//   - rst_ni=0 at a clock edge clears every stage valid bit.
//   - valid_o=0, result_o=0, mode_o=0 after that edge.
//   - In-flight data is discarded; nothing is emitted after release.
//   Handshake
//   - advance = !valid_o || ready_i; ready_o = advance.
//   - Whole pipe shifts only on advance; bubbles (valid=0) shift like data.
//   - Transfer in: valid_i && ready_o. Transfer out: valid_o && ready_i.
//   - While valid_o && !ready_i: result_o, mode_o and all stages hold stable.
//   - Never drops, duplicates or reorders transactions.
//   Latency and throughput
//   - Latency STAGES cycles from input transfer to valid_o with no stall.
//   - Throughput 1 result/cycle.
//   Datapath
//   - Stage k adds operand bits [k*SEG_W +: SEG_W] plus the registered carry from stage k-1.
//   - Stage 0 carry-in = 0 in exact mode.
//   - Operand segments not yet consumed are skew-delayed; finished sum segments are
//     de-skewed, so result_o is presented aligned.
//   - LOA mode, L = APPROX_BITS:
//       sum[L-1:0] = A[L-1:0] | B[L-1:0]
//       carry into bit L = A[L-1] & B[L-1]
//       bits >= L are exact.
//     L=0: LOA identical to exact. L=WIDTH: result = {A[W-1]&B[W-1], A|B}.
//   - The LOA boundary may fall inside a segment; the segment splits internally.
//   - Unsigned wrap: carry out of MSB goes to result_o[WIDTH], never lost.
// STRUCTURE
//   Package approx_adder_pkg:
//   - MODE_EXACT=1'b0, MODE_LOA=1'b1.
//   - Function loa_mask(WIDTH, APPROX_BITS).
//   - Parameter-legality checks (WIDTH % SEG_W == 0, APPROX_BITS <= WIDTH).
//   Sub-module adder_segment:
//   - SEG_W-bit ripple adder: a, b, cin, approx_mask -> sum, cout.
//   - Combinational; instantiated STAGES times via generate.
//   Top level owns skew/de-skew registers, valid/mode pipeline, stall logic.
// TESTING (default parameters, STAGES=4)
//   1 exact 16'h29AF+16'h7A1B, mode 0 -> after 4 cycles result_o=17'h0A3CA, mode_o=0
//   2 exact 16'h8943+16'hFFFF -> result_o=17'h18942 (carry-out set)
//   3 LOA 16'h29AF+16'h7A1B -> 17'h0A3CF; LOA 16'h5555+16'hAAAA -> 17'h0FFFF
//   4 8 back-to-back inputs, ready_i=1 -> 8 consecutive valid_o cycles, in order
//   5 stream 4 inputs, ready_i=0 for 3 cycles -> ready_o=0 while valid_o held,
//     result_o stable, all 4 results delivered once, in order
//   6 rst_ni=0 one edge with 3 in flight -> valid_o=0, result_o=0; none emitted after
//   Plus: random exact vs. golden A+B; random LOA vs. golden model; APPROX_BITS=0 and =6.

Source files
------------

// File: rtl/pipelined_approx_adder_pkg.sv
// Shared constants and elaboration helpers for the pipelined adder.
// Mode encoding, LOA mask builder and parameter legality check.
package approx_adder_pkg;

  localparam logic MODE_EXACT = 1'b0;
  localparam logic MODE_LOA   = 1'b1;
  localparam int   MAX_W      = 64;

  function automatic logic [MAX_W-1:0] loa_mask(
    input int width,
    input int approx_bits
  );
    logic [MAX_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width && i < approx_bits) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic bit params_ok(
    input int width,
    input int seg_w,
    input int approx_bits
  );
    return seg_w > 0 && width > 0 &&
           width <= MAX_W &&
           (width % seg_w) == 0 &&
           approx_bits >= 0 &&
           approx_bits <= width;
  endfunction

endpackage

// File: rtl/pipelined_approx_adder_if.sv
// Input/output valid-ready bundle of the pipelined adder.
// master drives operands and ready_i; slave is the adder.
interface pipelined_approx_adder_if #(
  parameter int WIDTH = 16
);
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] add1_i;
  logic [WIDTH-1:0] add2_i;
  logic             mode_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH:0]   result_o;
  logic             mode_o;

  modport master (
    output valid_i, add1_i, add2_i, mode_i, ready_i,
    input  ready_o, valid_o, result_o, mode_o
  );

  modport slave (
    input  valid_i, add1_i, add2_i, mode_i, ready_i,
    output ready_o, valid_o, result_o, mode_o
  );
endinterface

// File: rtl/pipelined_approx_adder_segment.sv
// One SEG_W-bit ripple segment; masked bits use OR for the sum and
// a&b as the carry to the next bit (lower-part-OR approximation).
module adder_segment #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] a_i,
  input  logic [SEG_W-1:0] b_i,
  input  logic [SEG_W-1:0] mask_i,
  input  logic             cin_i,
  output logic [SEG_W-1:0] sum_o,
  output logic             cout_o
);

  logic [SEG_W:0] c;

  always_comb begin
    c     = '0;
    sum_o = '0;
    c[0]  = cin_i;
    for (int i = 0; i < SEG_W; i++) begin
      if (mask_i[i]) begin
        sum_o[i] = a_i[i] | b_i[i];
        c[i+1]   = a_i[i] & b_i[i];
      end else begin
        sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
        c[i+1]   = (a_i[i] & b_i[i]) |
                   (c[i] & (a_i[i] ^ b_i[i]));
      end
    end
    cout_o = c[SEG_W];
  end

endmodule

// File: rtl/pipelined_approx_adder.sv
// Segmented, pipelined exact/LOA adder with a valid-ready stream.
// Stage k holds sum segments 0..k, its carry and the skewed operands.
module pipelined_approx_adder
  import approx_adder_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SEG_W       = 4,
  parameter int APPROX_BITS = 4
) (
  input logic clk_i,
  input logic rst_ni,
  pipelined_approx_adder_if.slave bus
);

  localparam int STAGES = WIDTH / SEG_W;
  localparam int LAST   = STAGES - 1;
  localparam logic [MAX_W-1:0] MASK_ALL =
    loa_mask(WIDTH, APPROX_BITS);
  localparam logic [WIDTH-1:0] LOA_MASK =
    MASK_ALL[WIDTH-1:0];

  if (!params_ok(WIDTH, SEG_W, APPROX_BITS)) begin : g_bad
    $error("pipelined_approx_adder: illegal parameters");
  end

  logic             v_q [STAGES];
  logic             v_d [STAGES];
  logic             m_q [STAGES];
  logic             m_d [STAGES];
  logic             c_q [STAGES];
  logic             c_d [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];

  logic             v_in [STAGES];
  logic             m_in [STAGES];
  logic             c_in [STAGES];
  logic [WIDTH-1:0] a_in [STAGES];
  logic [WIDTH-1:0] b_in [STAGES];
  logic [WIDTH-1:0] s_in [STAGES];

  logic [SEG_W-1:0] seg_a  [STAGES];
  logic [SEG_W-1:0] seg_b  [STAGES];
  logic [SEG_W-1:0] seg_m  [STAGES];
  logic [SEG_W-1:0] seg_s  [STAGES];
  logic             seg_co [STAGES];

  logic [WIDTH-1:0] loa_mask_w;
  logic             advance;

  assign loa_mask_w = LOA_MASK;
  assign advance    = !v_q[LAST] || bus.ready_i;

  // Stage 0 reads the ports; every later stage reads its predecessor.
  always_comb begin
    v_in[0] = bus.valid_i;
    m_in[0] = bus.mode_i;
    c_in[0] = 1'b0;
    a_in[0] = bus.add1_i;
    b_in[0] = bus.add2_i;
    s_in[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_in[k] = v_q[k-1];
      m_in[k] = m_q[k-1];
      c_in[k] = c_q[k-1];
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      seg_a[k] = a_in[k][k*SEG_W +: SEG_W];
      seg_b[k] = b_in[k][k*SEG_W +: SEG_W];
      seg_m[k] = (m_in[k] == MODE_LOA) ?
                 loa_mask_w[k*SEG_W +: SEG_W] : '0;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    adder_segment #(
      .SEG_W (SEG_W)
    ) u_seg (
      .a_i    (seg_a[k]),
      .b_i    (seg_b[k]),
      .mask_i (seg_m[k]),
      .cin_i  (c_in[k]),
      .sum_o  (seg_s[k]),
      .cout_o (seg_co[k])
    );
  end

  // The whole pipe moves as one; a stall freezes every stage.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      v_d[k] = v_q[k];
      m_d[k] = m_q[k];
      c_d[k] = c_q[k];
      a_d[k] = a_q[k];
      b_d[k] = b_q[k];
      s_d[k] = s_q[k];
      if (advance) begin
        v_d[k] = v_in[k];
        m_d[k] = m_in[k];
        c_d[k] = seg_co[k];
        a_d[k] = a_in[k];
        b_d[k] = b_in[k];
        s_d[k] = s_in[k];
        s_d[k][k*SEG_W +: SEG_W] = seg_s[k];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= 1'b0;
        m_q[k] <= MODE_EXACT;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_d[k];
        m_q[k] <= m_d[k];
        c_q[k] <= c_d[k];
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  assign bus.ready_o  = advance;
  assign bus.valid_o  = v_q[LAST];
  assign bus.mode_o   = m_q[LAST];
  assign bus.result_o = {c_q[LAST], s_q[LAST]};

endmodule

// File: tb/tb_pipelined_approx_adder.sv
// Self-checking bench: directed cases, stalls, reset flush and random
// streams against an arithmetic reference for L = 4, 0 and 6.
module tb_pipelined_approx_adder;

  localparam int W = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  pipelined_approx_adder_if #(.WIDTH(W)) bus4 ();
  pipelined_approx_adder_if #(.WIDTH(W)) bus0 ();
  pipelined_approx_adder_if #(.WIDTH(W)) bus6 ();

  pipelined_approx_adder #(
    .WIDTH(W), .SEG_W(4), .APPROX_BITS(4)
  ) u_dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus4));

  pipelined_approx_adder #(
    .WIDTH(W), .SEG_W(4), .APPROX_BITS(0)
  ) u_dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(bus0));

  pipelined_approx_adder #(
    .WIDTH(W), .SEG_W(4), .APPROX_BITS(6)
  ) u_dut6 (.clk_i(clk), .rst_ni(rst_n), .bus(bus6));

  int n_vec = 0;
  int n_err = 0;

  // LOA: low l bits are a|b, carry into bit l is a&b at bit l-1.
  function automatic logic [16:0] ref_sum(
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        m,
    input int          l
  );
    int unsigned ua, ub, lm, cy, hi;
    ua = {16'd0, a};
    ub = {16'd0, b};
    if (!m || l == 0) return 17'(ua + ub);
    lm = (32'd1 << l) - 32'd1;
    cy = ((ua & ub) >> (l - 1)) & 32'd1;
    hi = (ua >> l) + (ub >> l) + cy;
    return 17'((hi << l) | ((ua | ub) & lm));
  endfunction

  task automatic drive4(
    input logic        v,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic        m,
    input logic        r
  );
    bus4.valid_i = v;
    bus4.add1_i  = a;
    bus4.add2_i  = b;
    bus4.mode_i  = m;
    bus4.ready_i = r;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive4(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    @(negedge clk);
    n_vec++;
    if (bus4.valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_valid: got %b want 0", bus4.valid_o);
    end
    n_vec++;
    if (bus4.result_o !== 17'h0) begin
      n_err++;
      $display("FAIL reset_result: got %h want 0", bus4.result_o);
    end
    n_vec++;
    if (bus4.mode_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mode: got %b want 0", bus4.mode_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] da [4];
    logic [15:0] db [4];
    logic        dm [4];
    logic [17:0] dr [4];
    logic [17:0] q [$];
    int sent = 0, got = 0, first = -1;
    da = '{16'h29AF, 16'h8943, 16'h29AF, 16'h5555};
    db = '{16'h7A1B, 16'hFFFF, 16'h7A1B, 16'hAAAA};
    dm = '{1'b0, 1'b0, 1'b1, 1'b1};
    dr = '{{1'b0, 17'h0A3CA}, {1'b0, 17'h18942},
           {1'b1, 17'h0A3CF}, {1'b1, 17'h0FFFF}};
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      @(negedge clk);
      if (sent < 4) drive4(1'b1, da[sent], db[sent], dm[sent], 1'b1);
      else drive4(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
      #1;
      if (bus4.valid_i && bus4.ready_o) begin
        q.push_back(dr[sent]);
        sent++;
      end
      if (bus4.valid_o && bus4.ready_i) begin
        if (first < 0) first = cyc;
        n_vec++;
        if (q.size() == 0 ||
            {bus4.mode_o, bus4.result_o} !== q[0]) begin
          n_err++;
          $display("FAIL directed_%0d: got %h want %h", got,
                   {bus4.mode_o, bus4.result_o},
                   (q.size() > 0) ? q[0] : 18'h0);
        end
        if (q.size() > 0) void'(q.pop_front());
        got++;
      end
    end
    drive4(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    n_vec++;
    if (got != 4 || first != 4) begin
      n_err++;
      $display("FAIL directed_latency: got %0d results first at %0d want 4 at 4",
               got, first);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] q [$];
    logic [15:0] a, b;
    logic m;
    int sent = 0, got = 0, first = -1, last = -1;
    for (int cyc = 0; cyc < 30 && got < 8; cyc++) begin
      @(negedge clk);
      a = 16'($urandom);
      b = 16'($urandom);
      m = 1'($urandom);
      drive4(sent < 8, a, b, m, 1'b1);
      #1;
      if (bus4.valid_i && bus4.ready_o) begin
        q.push_back({m, ref_sum(a, b, m, 4)});
        sent++;
      end
      if (bus4.valid_o && bus4.ready_i) begin
        if (first < 0) first = cyc;
        last = cyc;
        n_vec++;
        if (q.size() == 0 ||
            {bus4.mode_o, bus4.result_o} !== q[0]) begin
          n_err++;
          $display("FAIL b2b_%0d: got %h want %h", got,
                   {bus4.mode_o, bus4.result_o},
                   (q.size() > 0) ? q[0] : 18'h0);
        end
        if (q.size() > 0) void'(q.pop_front());
        got++;
      end
    end
    drive4(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    n_vec++;
    if (got != 8 || first != 4 || last != 11) begin
      n_err++;
      $display("FAIL b2b_timing: got %0d from %0d to %0d want 8 from 4 to 11",
               got, first, last);
    end
  endtask

  task automatic test_stall();
    logic [17:0] q [$];
    logic [15:0] a, b;
    logic m, r;
    int sent = 0, got = 0, last = -1;
    for (int cyc = 0; cyc < 24 && got < 4; cyc++) begin
      @(negedge clk);
      a = 16'($urandom);
      b = 16'($urandom);
      m = 1'($urandom);
      r = !(cyc >= 4 && cyc <= 6);
      drive4(sent < 4, a, b, m, r);
      #1;
      if (bus4.valid_i && bus4.ready_o) begin
        q.push_back({m, ref_sum(a, b, m, 4)});
        sent++;
      end
      if (!r) begin
        n_vec++;
        if (bus4.valid_o !== 1'b1 || bus4.ready_o !== 1'b0 ||
            q.size() == 0 ||
            {bus4.mode_o, bus4.result_o} !== q[0]) begin
          n_err++;
          $display("FAIL stall_hold: valid_o=%b ready_o=%b out=%h want 1 0 %h",
                   bus4.valid_o, bus4.ready_o,
                   {bus4.mode_o, bus4.result_o},
                   (q.size() > 0) ? q[0] : 18'h0);
        end
      end
      if (bus4.valid_o && bus4.ready_i) begin
        last = cyc;
        n_vec++;
        if (q.size() == 0 ||
            {bus4.mode_o, bus4.result_o} !== q[0]) begin
          n_err++;
          $display("FAIL stall_out_%0d: got %h want %h", got,
                   {bus4.mode_o, bus4.result_o},
                   (q.size() > 0) ? q[0] : 18'h0);
        end
        if (q.size() > 0) void'(q.pop_front());
        got++;
      end
    end
    drive4(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    n_vec++;
    if (got != 4 || last != 10) begin
      n_err++;
      $display("FAIL stall_count: got %0d last at %0d want 4 last at 10",
               got, last);
    end
  endtask

  task automatic test_reset_flush();
    int seen = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clk);
      drive4(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
    end
    @(negedge clk);
    drive4(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus4.valid_o !== 1'b0 || bus4.result_o !== 17'h0 ||
        bus4.mode_o !== 1'b0) begin
      n_err++;
      $display("FAIL flush_reset: valid=%b result=%h mode=%b want 0 0 0",
               bus4.valid_o, bus4.result_o, bus4.mode_o);
    end
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(negedge clk);
      if (bus4.valid_o !== 1'b0) seen++;
    end
    n_vec++;
    if (seen != 0) begin
      n_err++;
      $display("FAIL flush_ghost: got %0d valid cycles want 0", seen);
    end
  endtask

  task automatic test_random(input int n);
    logic [17:0] q [$];
    logic [15:0] a, b;
    logic m, v, r;
    int sent = 0, cyc = 0;
    while ((sent < n || q.size() > 0) && cyc < n * 10) begin
      @(negedge clk);
      a = 16'($urandom);
      b = 16'($urandom);
      m = 1'($urandom);
      v = (sent < n) && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 9) < 7);
      drive4(v, a, b, m, r);
      #1;
      if (bus4.valid_i && bus4.ready_o) begin
        q.push_back({m, ref_sum(a, b, m, 4)});
        sent++;
      end
      if (bus4.valid_o && bus4.ready_i) begin
        n_vec++;
        if (q.size() == 0 ||
            {bus4.mode_o, bus4.result_o} !== q[0]) begin
          n_err++;
          $display("FAIL random: got %h want %h",
                   {bus4.mode_o, bus4.result_o},
                   (q.size() > 0) ? q[0] : 18'h0);
        end
        if (q.size() > 0) void'(q.pop_front());
      end
      cyc++;
    end
    drive4(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    n_vec++;
    if (sent != n || q.size() != 0) begin
      n_err++;
      $display("FAIL random_drain: sent %0d pending %0d want %0d 0",
               sent, q.size(), n);
    end
  endtask

  task automatic test_approx_bits(input int n);
    logic [17:0] q0 [$];
    logic [17:0] q6 [$];
    logic [15:0] a, b;
    logic m;
    int sent = 0, got0 = 0, got6 = 0;
    for (int cyc = 0; cyc < n + 20 && (got0 < n || got6 < n); cyc++) begin
      @(negedge clk);
      if (sent == 0) begin
        a = 16'h29AF;
        b = 16'h7A1B;
        m = 1'b1;
      end else begin
        a = 16'($urandom);
        b = 16'($urandom);
        m = 1'($urandom);
      end
      bus0.valid_i = (sent < n);
      bus0.add1_i  = a;
      bus0.add2_i  = b;
      bus0.mode_i  = m;
      bus6.valid_i = (sent < n);
      bus6.add1_i  = a;
      bus6.add2_i  = b;
      bus6.mode_i  = m;
      #1;
      if (bus0.valid_i && bus0.ready_o && bus6.ready_o) begin
        if (sent == 0) begin
          q0.push_back({1'b1, 17'h0A3CA});
          q6.push_back({1'b1, 17'h0A3BF});
        end else begin
          q0.push_back({m, ref_sum(a, b, m, 0)});
          q6.push_back({m, ref_sum(a, b, m, 6)});
        end
        sent++;
      end
      if (bus0.valid_o && bus0.ready_i) begin
        n_vec++;
        if (q0.size() == 0 ||
            {bus0.mode_o, bus0.result_o} !== q0[0]) begin
          n_err++;
          $display("FAIL loa_l0_%0d: got %h want %h", got0,
                   {bus0.mode_o, bus0.result_o},
                   (q0.size() > 0) ? q0[0] : 18'h0);
        end
        if (q0.size() > 0) void'(q0.pop_front());
        got0++;
      end
      if (bus6.valid_o && bus6.ready_i) begin
        n_vec++;
        if (q6.size() == 0 ||
            {bus6.mode_o, bus6.result_o} !== q6[0]) begin
          n_err++;
          $display("FAIL loa_l6_%0d: got %h want %h", got6,
                   {bus6.mode_o, bus6.result_o},
                   (q6.size() > 0) ? q6[0] : 18'h0);
        end
        if (q6.size() > 0) void'(q6.pop_front());
        got6++;
      end
    end
    bus0.valid_i = 1'b0;
    bus6.valid_i = 1'b0;
    n_vec++;
    if (got0 != n || got6 != n) begin
      n_err++;
      $display("FAIL loa_count: got %0d and %0d want %0d each",
               got0, got6, n);
    end
  endtask

  initial begin
    drive4(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    bus0.valid_i = 1'b0;
    bus0.add1_i  = '0;
    bus0.add2_i  = '0;
    bus0.mode_i  = 1'b0;
    bus0.ready_i = 1'b1;
    bus6.valid_i = 1'b0;
    bus6.add1_i  = '0;
    bus6.add2_i  = '0;
    bus6.mode_i  = 1'b0;
    bus6.ready_i = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_flush();
    test_random(300);
    test_approx_bits(60);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
